// File: rtl/spi_slave_rx.sv
// spi_slave_rx: mode-0 SPI slave receiver with synchronized cs/sclk/mosi and word/frame strobes.
// Define SPI_SLAVE_RX_MISO_EN to add the tx_din/tx_load/miso transmit path.
module spi_slave_rx #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cs,
   input  logic                  sclk,
   input  logic                  mosi,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  frame_err,
   output logic                  busy
`ifdef SPI_SLAVE_RX_MISO_EN
   ,
   input  logic [DATA_WIDTH-1:0] tx_din,
   input  logic                  tx_load,
   output logic                  miso
`endif
);
   localparam int CW = $clog2(DATA_WIDTH);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t                  state, state_n;
   logic [SYNC_STAGES-1:0]  cs_sync, sclk_sync, mosi_sync;
   logic                    sclk_d, cs_s, sclk_s, mosi_s, rise, wrap;
   logic [CW-1:0]           cnt, cnt_n;
   logic [DATA_WIDTH-1:0]   shift, shift_n, dout_n;
   logic                    valid_n, ferr_n;
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign rise   = sclk_s & ~sclk_d;
   assign wrap   = rise && cnt == CW'(DATA_WIDTH-1);
   assign busy   = state == ACTIVE;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_d    <= sclk_s;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         shift      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         shift      <= shift_n;
         dout       <= dout_n;
         dout_valid <= valid_n;
         frame_err  <= ferr_n;
      end
   end
   // a final edge coinciding with cs release completes the word before the frame check
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shift_n = shift;
      dout_n  = dout;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
      if (state == IDLE) begin
         if (!cs_s) begin
            state_n = ACTIVE;
            cnt_n   = '0;
            shift_n = '0;
         end
      end else begin
         if (rise) begin
            shift_n = {shift[DATA_WIDTH-2:0], mosi_s};
            cnt_n   = wrap ? '0 : cnt + CW'(1);
            dout_n  = wrap ? shift_n : dout;
            valid_n = wrap;
         end
         if (cs_s) begin
            state_n = IDLE;
            ferr_n  = cnt_n != '0;
         end
      end
   end
`ifdef SPI_SLAVE_RX_MISO_EN
   logic [DATA_WIDTH-1:0] tx_hold, tx_shift;
   logic                  fall, load_tx;
   assign fall    = ~sclk_s & sclk_d;
   assign load_tx = (state == IDLE && !cs_s) || (state == ACTIVE && wrap);
   assign miso    = busy & tx_shift[DATA_WIDTH-1];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_hold  <= '0;
         tx_shift <= '0;
      end else begin
         if (tx_load) tx_hold <= tx_din;
         if (load_tx) tx_shift <= tx_hold;
         else if (busy && fall) tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      end
   end
`endif
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: randomized SPI frames against a queue-based model of received words and frame errors.
module tb_spi_slave_rx;
   localparam int W  = 8;
   localparam int SS = 2;
   logic clk = 1'b0, rst = 1'b1, cs = 1'b1, sclk = 1'b0, mosi = 1'b0;
   logic [W-1:0] dout;
   logic dout_valid, frame_err, busy;
`ifdef SPI_SLAVE_RX_MISO_EN
   logic [W-1:0] tx_din = '0;
   logic tx_load = 1'b0;
   logic miso;
`endif
   int checks = 0, errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] m_dout = '0;
   logic [W-1:0] miso_cap = '0;
   logic [W-1:0] words [0:3];
   int exp_ferr = 0, valid_seen = 0, ferr_seen = 0;
   logic busy_known = 1'b0, exp_busy = 1'b0;

   spi_slave_rx #(.DATA_WIDTH(W), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi),
      .dout(dout), .dout_valid(dout_valid), .frame_err(frame_err), .busy(busy)
`ifdef SPI_SLAVE_RX_MISO_EN
      , .tx_din(tx_din), .tx_load(tx_load), .miso(miso)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: every completed word is queued when its last bit is clocked; strobes consume the queue
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("rst_dout", dout, 0);
         chk("rst_valid", dout_valid, 0);
         chk("rst_ferr", frame_err, 0);
         chk("rst_busy", busy, 0);
         m_dout = '0;
      end else begin
         if (dout_valid) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid dout %0h expected no strobe", dout);
            end else m_dout = exp_q.pop_front();
         end
         chk("dout", dout, m_dout);
         if (frame_err) begin
            ferr_seen++;
            checks++;
            if (exp_ferr == 0) begin
               errors++;
               $display("FAIL unexpected_frame_err got 1 expected 0");
            end else exp_ferr--;
         end
         if (busy_known) chk("busy", busy, exp_busy);
`ifdef SPI_SLAVE_RX_MISO_EN
         if (busy_known && !exp_busy) chk("miso_idle", miso, 0);
`endif
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
      $fatal(1, "timeout");
   end

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [W-1:0] w, input int nb, input int h);
      for (int i = 0; i < nb; i++) begin
         mosi = w[W-1-i];
         wclk(h);
`ifdef SPI_SLAVE_RX_MISO_EN
         miso_cap[W-1-i] = miso;
`endif
         if (nb == W && i == W-1) exp_q.push_back(w);
         sclk = 1'b1;
         wclk(h);
         sclk = 1'b0;
      end
   endtask

   task automatic frame(input int nw, input int tail, input int h);
      busy_known = 1'b0;
      cs = 1'b0;
      wclk(SS+2);
      exp_busy = 1'b1;
      busy_known = 1'b1;
      for (int k = 0; k < nw; k++) send_bits(words[k], W, h);
      if (tail > 0) send_bits(words[nw], tail, h);
      wclk(h);
      busy_known = 1'b0;
      if (tail > 0) exp_ferr++;
      cs = 1'b1;
      wclk(SS+2);
      exp_busy = 1'b0;
      busy_known = 1'b1;
      wclk(h);
   endtask

   task automatic idle_toggle(input int h);
      for (int i = 0; i < 8; i++) begin
         mosi = 1'($urandom);
         wclk(h);
         sclk = 1'b1;
         wclk(h);
         sclk = 1'b0;
      end
      wclk(h);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || exp_ferr != 0) && n < 50) begin
         wclk(1);
         n++;
      end
      chk({name, "_pending_words"}, exp_q.size(), 0);
      chk({name, "_pending_ferr"}, exp_ferr, 0);
   endtask

   initial begin
      int v0, f0, nw, tail, h;
      #1 rst = 1'b0;
      wclk(3);
      rst = 1'b1;
      wclk(2);
      exp_busy = 1'b0;
      busy_known = 1'b1;
      chk("post_reset_dout", dout, 0);
      // single word
      v0 = valid_seen; f0 = ferr_seen;
      words[0] = 8'hA5;
      frame(1, 0, 4);
      drain("a5");
      chk("a5_dout", dout, 8'hA5);
      chk("a5_valid_count", valid_seen - v0, 1);
      chk("a5_ferr_count", ferr_seen - f0, 0);
      // two words in one frame
      v0 = valid_seen;
      words[0] = 8'h3C; words[1] = 8'hC3;
      frame(2, 0, 4);
      drain("3c_c3");
      chk("3c_c3_dout", dout, 8'hC3);
      chk("3c_c3_valid_count", valid_seen - v0, 2);
      // cs released after 5 bits
      v0 = valid_seen; f0 = ferr_seen;
      words[0] = 8'hFF;
      frame(0, 5, 4);
      drain("trunc");
      chk("trunc_dout", dout, 8'hC3);
      chk("trunc_valid_count", valid_seen - v0, 0);
      chk("trunc_ferr_count", ferr_seen - f0, 1);
      // reset mid-word, then a fresh frame
      v0 = valid_seen; f0 = ferr_seen;
      busy_known = 1'b0;
      cs = 1'b0;
      wclk(SS+2);
      send_bits(8'hF0, 4, 4);
      rst = 1'b0;
      wclk(3);
      cs = 1'b1;
      wclk(2);
      rst = 1'b1;
      wclk(SS+2);
      exp_busy = 1'b0;
      busy_known = 1'b1;
      chk("rst_mid_dout", dout, 0);
      words[0] = 8'h81;
      frame(1, 0, 4);
      drain("81");
      chk("81_dout", dout, 8'h81);
      chk("81_valid_count", valid_seen - v0, 1);
      chk("81_ferr_count", ferr_seen - f0, 0);
      // last rising edge coincides with cs release
      v0 = valid_seen; f0 = ferr_seen;
      busy_known = 1'b0;
      cs = 1'b0;
      wclk(SS+2);
      send_bits(8'h6E, W-1, 4);
      mosi = 1'b0;
      wclk(4);
      exp_q.push_back(8'h6E);
      sclk = 1'b1;
      cs = 1'b1;
      wclk(4);
      sclk = 1'b0;
      wclk(SS+2);
      exp_busy = 1'b0;
      busy_known = 1'b1;
      drain("same_cycle");
      chk("same_cycle_dout", dout, 8'h6E);
      chk("same_cycle_valid_count", valid_seen - v0, 1);
      chk("same_cycle_ferr_count", ferr_seen - f0, 0);
      // sclk activity with cs high
      v0 = valid_seen; f0 = ferr_seen;
      idle_toggle(4);
      chk("idle_valid_count", valid_seen - v0, 0);
      chk("idle_ferr_count", ferr_seen - f0, 0);
      chk("idle_busy", busy, 0);
`ifdef SPI_SLAVE_RX_MISO_EN
      tx_din = 8'h5A;
      tx_load = 1'b1;
      wclk(1);
      tx_load = 1'b0;
      tx_din = 8'h00;
      words[0] = 8'h00;
      frame(1, 0, 4);
      drain("miso");
      chk("miso_bits", miso_cap, 8'h5A);
      chk("miso_dout", dout, 8'h00);
`endif
      // randomized frames
      for (int it = 0; it < 30; it++) begin
         nw = $urandom_range(1, 3);
         tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W-1) : 0;
         h = $urandom_range(SS+1, SS+4);
         for (int k = 0; k < 4; k++) words[k] = W'($urandom);
         frame(nw, tail, h);
         if ($urandom_range(0, 4) == 0) idle_toggle(h);
         drain("rand");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
